// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 pipeline controller: opcodes, memory-interface
// codes, controller states and small opcode classification helpers.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  localparam logic [1:0] READ  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] IND   = 2'd2;
  localparam logic [1:0] IDLE  = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CTL_WAIT = 2'd1,
    MEM_IND  = 2'd2,
    MEM_RW   = 2'd3
  } ctrl_state_t;

  function automatic logic is_ctl_op(opcode_t op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  function automatic logic is_mem_op(opcode_t op);
    return op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
  endfunction

  function automatic logic is_indirect_op(opcode_t op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_load_op(opcode_t op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

endpackage

// File: rtl/lc3_br_eval.sv
// Resolves whether the control instruction in execute redirects the PC:
// JMP always does, BR does when any requested NZP flag is set.
module lc3_br_eval
  import lc3_pkg::*;
(
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        taken
);

  opcode_t op;
  logic    unused_ir_bits;

  assign op             = opcode_t'(IR_Exec[15:12]);
  assign unused_ir_bits = ^IR_Exec[8:0];
  assign taken          = (op == OP_JMP) || ((op == OP_BR) && (|(IR_Exec[11:9] & psr)));

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: sequences fetch/decode/execute/writeback enables
// around control-flow bubbles and multi-cycle data-memory accesses.
module lc3_pipe_ctrl
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  ctrl_state_t state, state_nxt;
  logic [1:0]  bubble_cnt, bubble_nxt;
  opcode_t     mem_op, mem_op_nxt;
  opcode_t     dec_op, exe_op;
  logic        taken;
  logic        unused_ir_bits;

  logic fetch_c, update_c, decode_c, execute_c, writeback_c, br_c;
  logic [1:0] mem_c;

  assign dec_op         = opcode_t'(IR[15:12]);
  assign exe_op         = opcode_t'(IR_Exec[15:12]);
  assign unused_ir_bits = ^IR[11:0];

  lc3_br_eval u_br_eval (
    .IR_Exec (IR_Exec),
    .psr     (psr),
    .taken   (taken)
  );

  // A memory op in execute wins over a control op in decode; the bubble
  // count is still loaded and simply sits untouched until the access ends.
  always_comb begin
    state_nxt  = state;
    bubble_nxt = bubble_cnt;
    mem_op_nxt = mem_op;
    case (state)
      RUN: begin
        if (complete_instr) begin
          if (is_ctl_op(dec_op)) begin
            bubble_nxt = 2'd2;
            state_nxt  = CTL_WAIT;
          end
          if (is_mem_op(exe_op)) begin
            mem_op_nxt = exe_op;
            state_nxt  = is_indirect_op(exe_op) ? MEM_IND : MEM_RW;
          end
        end
      end
      CTL_WAIT: begin
        if (bubble_cnt <= 2'd1) begin
          bubble_nxt = 2'd0;
          state_nxt  = RUN;
        end else begin
          bubble_nxt = bubble_cnt - 2'd1;
        end
      end
      MEM_IND: begin
        if (complete_data) state_nxt = MEM_RW;
      end
      MEM_RW: begin
        if (complete_data) state_nxt = (bubble_cnt != 2'd0) ? CTL_WAIT : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      bubble_cnt <= 2'd0;
      mem_op     <= OP_ADD;
    end else begin
      state      <= state_nxt;
      bubble_cnt <= bubble_nxt;
      mem_op     <= mem_op_nxt;
    end
  end

  // The PC reloads one cycle before the bubble ends, once the control
  // instruction has reached execute; fetch stays off in that cycle.
  always_comb begin
    fetch_c     = 1'b0;
    update_c    = 1'b0;
    decode_c    = 1'b0;
    execute_c   = 1'b0;
    writeback_c = 1'b0;
    br_c        = 1'b0;
    mem_c       = IDLE;
    case (state)
      RUN: begin
        fetch_c     = complete_instr;
        update_c    = complete_instr;
        decode_c    = complete_instr;
        execute_c   = complete_instr;
        writeback_c = complete_instr;
      end
      CTL_WAIT: begin
        execute_c   = 1'b1;
        writeback_c = 1'b1;
        update_c    = (bubble_cnt == 2'd1);
        br_c        = (bubble_cnt == 2'd1) && taken;
      end
      MEM_IND: mem_c = IND;
      MEM_RW: begin
        mem_c       = is_load_op(mem_op) ? READ : WRITE;
        writeback_c = complete_data && is_load_op(mem_op);
      end
      default: mem_c = IDLE;
    endcase
  end

  assign enable_fetch     = reset && fetch_c;
  assign enable_updatePC  = reset && update_c;
  assign enable_decode    = reset && decode_c;
  assign enable_execute   = reset && execute_c;
  assign enable_writeback = reset && writeback_c;
  assign br_taken         = reset && br_c;
  assign mem_state        = reset ? mem_c : IDLE;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Self-checking bench for lc3_pipe_ctrl: directed scenarios pinned by literal
// expectations plus randomized traffic compared against a pipeline model.
module tb_lc3_pipe_ctrl;

  localparam logic [15:0] ADD = 16'h1261;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        complete_instr = 1'b0;
  logic        complete_data = 1'b0;
  logic [15:0] IR = ADD;
  logic [15:0] IR_Exec = ADD;
  logic [2:0]  psr = 3'b000;
  logic        enable_fetch, enable_updatePC, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic [1:0]  mem_state;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model: stall cycles still owed to a control op, and the memory access in flight.
  int m_bubble = 0;
  bit m_busy = 1'b0;
  bit m_ind = 1'b0;
  bit m_store = 1'b0;

  lc3_pipe_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_updatePC  (enable_updatePC),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_bundle();
    return {enable_fetch, enable_updatePC, enable_decode, enable_execute,
            enable_writeback, br_taken, mem_state};
  endfunction

  function automatic logic [7:0] model_expected();
    logic [4:0] en;
    logic       br;
    logic [1:0] ms;
    int         op;
    en = 5'b0;
    br = 1'b0;
    ms = 2'd3;
    op = int'(IR_Exec[15:12]);
    if (!reset) begin
      ms = 2'd3;
    end else if (m_busy) begin
      ms = m_ind ? 2'd2 : (m_store ? 2'd1 : 2'd0);
      if (!m_ind && !m_store && complete_data) en = 5'b00001;
    end else if (m_bubble > 0) begin
      en = (m_bubble == 1) ? 5'b01011 : 5'b00011;
      if (m_bubble == 1) br = (op == 12) || (op == 0 && (IR_Exec[11:9] & psr) != 3'b000);
    end else begin
      en = {5{complete_instr}};
    end
    return {en, br, ms};
  endfunction

  function automatic void model_advance();
    int dop;
    int eop;
    dop = int'(IR[15:12]);
    eop = int'(IR_Exec[15:12]);
    if (!reset) begin
      m_bubble = 0;
      m_busy   = 1'b0;
      m_ind    = 1'b0;
      m_store  = 1'b0;
    end else if (m_busy) begin
      if (complete_data) begin
        if (m_ind) m_ind = 1'b0;
        else m_busy = 1'b0;
      end
    end else if (m_bubble > 0) begin
      m_bubble = m_bubble - 1;
    end else if (complete_instr) begin
      if (dop == 0 || dop == 12) m_bubble = 2;
      if (eop inside {2, 3, 6, 7, 10, 11}) begin
        m_busy  = 1'b1;
        m_ind   = (eop == 10 || eop == 11);
        m_store = (eop == 3 || eop == 7 || eop == 11);
      end
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic ci, input logic cd,
                               input logic [15:0] ir, input logic [15:0] irx,
                               input logic [2:0] p);
    logic [7:0] exp_v;
    logic [7:0] act_v;
    @(negedge clk);
    reset          = rst;
    complete_instr = ci;
    complete_data  = cd;
    IR             = ir;
    IR_Exec        = irx;
    psr            = p;
    #1;
    exp_v = model_expected();
    act_v = dut_bundle();
    n_vectors++;
    if (act_v !== exp_v) begin
      n_miscompares++;
      $display("[TB] FAIL model t=%0t actual=%b required=%b", $time, act_v, exp_v);
    end
    model_advance();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] required);
    logic [7:0] act_v;
    act_v = dut_bundle();
    n_vectors++;
    if (act_v !== required) begin
      n_miscompares++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act_v, required);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) == 0) v[15:12] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1100;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Bundle layout: {fetch, updatePC, decode, execute, writeback, br_taken, mem_state[1:0]}
    applyStimulus(0, 1, 0, ADD, ADD, 3'b000);  checkOutput("reset_hold", 8'h03);
    applyStimulus(0, 1, 1, ADD, ADD, 3'b000);  checkOutput("reset_hold_cd", 8'h03);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, ADD, ADD, 3'b000);  checkOutput("add_stream", 8'hFB);
    end
    applyStimulus(0, 1, 0, ADD, ADD, 3'b000);  checkOutput("reset_midrun", 8'h03);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);  checkOutput("first_after_reset", 8'hFB);

    applyStimulus(1, 0, 0, 16'h0E02, ADD, 3'b010);  checkOutput("no_instr", 8'h03);
    applyStimulus(1, 1, 1, ADD, ADD, 3'b000);       checkOutput("cd_ignored_run", 8'hFB);

    applyStimulus(1, 1, 0, 16'h0E02, ADD, 3'b010);  checkOutput("br_accept", 8'hFB);
    applyStimulus(1, 1, 1, ADD, ADD, 3'b010);       checkOutput("br_stall", 8'h1B);
    applyStimulus(1, 1, 0, ADD, 16'h0E02, 3'b010);  checkOutput("br_taken", 8'h5F);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b010);       checkOutput("br_resume", 8'hFB);

    applyStimulus(1, 1, 0, 16'h0802, ADD, 3'b001);  checkOutput("brn_accept", 8'hFB);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b001);       checkOutput("brn_stall", 8'h1B);
    applyStimulus(1, 1, 0, ADD, 16'h0802, 3'b001);  checkOutput("brn_not_taken", 8'h5B);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b001);       checkOutput("brn_resume", 8'hFB);

    applyStimulus(1, 1, 0, ADD, 16'hA401, 3'b000);  checkOutput("ldi_accept", 8'hFB);
    applyStimulus(1, 1, 0, ADD, 16'h3000, 3'b000);  checkOutput("ldi_ind1", 8'h02);
    applyStimulus(1, 1, 0, ADD, 16'h3000, 3'b000);  checkOutput("ldi_ind2", 8'h02);
    applyStimulus(1, 1, 1, ADD, 16'h3000, 3'b000);  checkOutput("ldi_ind3", 8'h02);
    applyStimulus(1, 1, 0, ADD, 16'h3000, 3'b000);  checkOutput("ldi_read1", 8'h00);
    applyStimulus(1, 1, 1, ADD, 16'h3000, 3'b000);  checkOutput("ldi_writeback", 8'h08);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);       checkOutput("ldi_resume", 8'hFB);

    applyStimulus(1, 1, 0, 16'hC1C0, 16'h7442, 3'b000);  checkOutput("str_jmp_accept", 8'hFB);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);            checkOutput("str_write1", 8'h01);
    applyStimulus(1, 1, 0, ADD, 16'h2000, 3'b000);       checkOutput("str_write2", 8'h01);
    applyStimulus(1, 1, 1, ADD, ADD, 3'b000);            checkOutput("str_done_no_wb", 8'h01);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);            checkOutput("jmp_stall", 8'h1B);
    applyStimulus(1, 1, 0, ADD, 16'hC1C0, 3'b000);       checkOutput("jmp_taken", 8'h5F);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);            checkOutput("jmp_resume", 8'hFB);

    applyStimulus(1, 1, 0, ADD, 16'h2000, 3'b000);  checkOutput("ld_accept", 8'hFB);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);       checkOutput("ld_wait", 8'h00);
    applyStimulus(0, 1, 1, ADD, ADD, 3'b000);       checkOutput("reset_mid_access", 8'h03);
    applyStimulus(1, 1, 0, ADD, ADD, 3'b000);       checkOutput("run_after_abort", 8'hFB);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(logic'($urandom_range(0, 99) != 0),
                    logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 2) == 0),
                    rand_instr(), rand_instr(), 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_ctrl.md
LC3_PIPE_CTRL -- requirements
Module: lc3_pipe_ctrl

Interface
REQ-001 The block SHALL provide these ports (name, direction, width, meaning), clock and reset first.
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- complete_instr  in  1  instruction memory returned valid Instr_dout this cycle
- complete_data  in  1  data memory access finished this cycle
- IR  in  16  instruction held in decode
- IR_Exec  in  16  instruction held in execute
- psr  in  3  NZP condition flags from writeback
- enable_fetch  out  1  fetch stage advance; mirrors instrmem_rd
- enable_updatePC  out  1  PC register load enable
- enable_decode  out  1  decode register load enable
- enable_execute  out  1  execute register load enable
- enable_writeback  out  1  register-file write enable
- br_taken  out  1  PC loads pcout instead of npc
- mem_state  out  2  0 read, 1 write, 2 indirect read, 3 idle

Function
REQ-002 The block SHALL implement the states RUN, CTL_WAIT, MEM_IND, MEM_RW.
REQ-003 In RUN with complete_instr=1 and no hazard, the block SHALL drive all five enables to 1, mem_state=3 and br_taken=0.
REQ-004 In RUN with complete_instr=0, the block SHALL drive all enables to 0 and SHALL remain in RUN.
REQ-005 When IR[15:12] is BR (0000) or JMP (1100) with enable_decode=1, the block SHALL enter CTL_WAIT on the next edge and load a 2-bit bubble counter with 2.
REQ-006 In CTL_WAIT, the block SHALL hold enable_fetch=enable_updatePC=enable_decode=0 and enable_execute=enable_writeback=1, decrementing the counter each cycle.
REQ-007 In the cycle the counter reads 1, IR_Exec holds the control instruction, so the block SHALL drive enable_updatePC=1 and br_taken = (JMP) or (BR and |(IR_Exec[11:9] & psr)).
REQ-008 When the counter reaches 0, the block SHALL return to RUN.
REQ-009 An untaken BR SHALL still cost the full bubble; no prediction is performed.
REQ-010 When IR_Exec[15:12] is LD, LDR, ST or STR with enable_execute=1, the block SHALL enter MEM_RW on the next edge.
REQ-011 When IR_Exec[15:12] is LDI or STI with enable_execute=1, the block SHALL enter MEM_IND on the next edge.
REQ-012 In MEM_IND, the block SHALL drive mem_state=2 with all enables 0 until complete_data=1, then enter MEM_RW.
REQ-013 In MEM_RW, the block SHALL drive mem_state=0 for LD/LDR/LDI and 1 for ST/STR/STI, with all enables 0, until complete_data=1.
REQ-014 In the complete_data cycle of MEM_RW, the block SHALL pulse enable_writeback=1 for loads only, then return to RUN (or to CTL_WAIT if the counter is nonzero).
REQ-015 If a memory op in execute and a control op in decode coincide, the memory op SHALL take priority, and the bubble counter SHALL be loaded but frozen until MEM_RW exits.
REQ-016 complete_data asserted in RUN or CTL_WAIT SHALL be ignored.
REQ-017 The block SHALL latch the opcode of the memory instruction on MEM entry; later IR_Exec changes SHALL NOT alter mem_state.
REQ-018 enable_fetch SHALL equal enable_updatePC in every state except the REQ-007 cycle, where enable_fetch SHALL be 0.

Reset
REQ-019 While reset=0, the block SHALL drive all enables to 0, br_taken=0, mem_state=3, state=RUN and counter=0, asynchronously.
REQ-020 Reset asserted mid-access SHALL abandon the access immediately, with no writeback pulse.
REQ-021 The first rising edge after reset=1 SHALL evaluate RUN normally.

Structure
REQ-022 Package lc3_pkg SHALL hold the 4-bit opcode enum, the mem_state constants (READ=0, WRITE=1, IND=2, IDLE=3) and the controller state enum.
REQ-023 Branch-condition evaluation SHALL live in sub-module lc3_br_eval (IR_Exec, psr -> taken).
REQ-024 All outputs SHALL be decoded from registered state and counter plus the current inputs; no combinational loop SHALL exist through complete_*.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- reset=0 mid-run -> same cycle: all enables 0, mem_state=3, br_taken=0.
- ADD stream 0x1261 repeated, complete_instr=1 -> all enables 1 every cycle.
- BR 0x0E02 in decode, psr=3'b010 -> 2 stall cycles, br_taken=1 in the counter=1 cycle.
- BR 0x0802 (n only), psr=3'b001 -> same bubble, br_taken=0.
- LDI 0xA401 in execute, complete_data after 3 and 2 cycles -> mem_state 2,2,2 then 0,0, single enable_writeback pulse, then RUN.
- STR 0x7442 in execute while JMP 0xC1C0 in decode -> mem_state=1 until complete_data, no writeback pulse, then CTL_WAIT with br_taken=1.
